// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC register, req/ack memory handshake,
// one-entry hold buffer for decode stalls and redirect/flush handling.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
);
    typedef enum logic {REQ, HOLD} state_t;

    state_t      state;
    logic [31:0] pc, pend_pc, buf_instr, buf_pc, rd_pc;
    logic        pend, go, direct, park, unpark;

    assign imem_addr = pc;
    assign rd_pc     = redirect_pc & ~32'd3;
    // a returned word is usable only when no redirect is current or pending
    assign go        = state == REQ && imem_req && imem_ack && !redirect && !pend;
    assign direct    = go && (!ifid_valid || !stall_id);
    assign park      = go && ifid_valid && stall_id;
    assign unpark    = state == HOLD && !redirect && !stall_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            pend       <= 1'b0;
            pend_pc    <= 32'd0;
            buf_instr  <= NOP_WORD;
            buf_pc     <= 32'd0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd0;
        end else begin
            if (state == REQ) begin
                if (!imem_req) begin
                    imem_req <= 1'b1;
                end else if (imem_ack) begin
                    pend <= 1'b0;
                    if (redirect || pend) begin
                        pc <= redirect ? rd_pc : pend_pc;
                    end else begin
                        pc <= pc + 32'd4;
                        if (park) begin
                            state     <= HOLD;
                            imem_req  <= 1'b0;
                            buf_instr <= imem_rdata;
                            buf_pc    <= pc;
                        end
                    end
                end else if (redirect) begin
                    pend    <= 1'b1;
                    pend_pc <= rd_pc;
                end
            end else if (redirect || !stall_id) begin
                state    <= REQ;
                imem_req <= 1'b1;
                if (redirect) pc <= rd_pc;
            end
            if (redirect) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_WORD;
            end else if (direct || unpark) begin
                ifid_valid <= 1'b1;
                ifid_instr <= direct ? imem_rdata : buf_instr;
                ifid_pc    <= direct ? pc : buf_pc;
                ifid_pc4   <= (direct ? pc : buf_pc) + 32'd4;
            end else if (ifid_valid && !stall_id) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_WORD;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan scenarios, then randomized traffic checked
// against an expected-instruction-stream scoreboard.
module tb_if_stage;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, stall_id = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc, ifid_pc4;

    int checks = 0, failures = 0;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall_id(stall_id),
        .redirect(redirect), .redirect_pc(redirect_pc), .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4)
    );

    assign imem_rdata = imem_addr ^ KEY;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, imem_req, 0);
        check({tag, "_valid"}, ifid_valid, 0);
        check({tag, "_instr"}, ifid_instr, 0);
        check({tag, "_pc"}, ifid_pc, 0);
        check({tag, "_pc4"}, ifid_pc4, 0);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] p);
        check({tag, "_valid"}, ifid_valid, 1);
        check({tag, "_pc"}, ifid_pc, p);
        check({tag, "_instr"}, ifid_instr, p ^ KEY);
        check({tag, "_pc4"}, ifid_pc4, p + 32'd4);
    endtask

    initial begin
        logic [31:0] exp_pc;
        bit          exp_flush;
        int          idle;
        #3 check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        check("start_req", imem_req, 1);
        check("start_addr", imem_addr, 0);
        check("start_valid", ifid_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_ifid("seq", 32'(i * 4));
        end
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_ifid("stall", 32'd8);
            check("stall_req", imem_req, 0);
        end
        stall_id = 1'b0;
        @(negedge clk);
        check_ifid("unhold", 32'd12);
        check("unhold_addr", imem_addr, 32'd16);
        @(negedge clk);
        check_ifid("after_hold", 32'd16);
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        check("redir_flush", ifid_valid, 0);
        check("redir_nop", ifid_instr, 0);
        check("redir_addr_hold", imem_addr, 32'd20);
        @(negedge clk);
        check("redir_addr_hold2", imem_addr, 32'd20);
        imem_ack = 1'b1;
        @(negedge clk);
        check("redir_target", imem_addr, 32'h100);
        check("redir_discard", ifid_valid, 0);
        @(negedge clk);
        check_ifid("redir_first", 32'h100);
        stall_id = 1'b1;
        @(negedge clk);
        check("hold_req", imem_req, 0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        stall_id = 1'b0;
        check("hold_flush", ifid_valid, 0);
        check("hold_redir_addr", imem_addr, 32'h200);
        check("hold_redir_req", imem_req, 1);
        @(negedge clk);
        check_ifid("hold_redir_first", 32'h200);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_flush", ifid_valid, 0);
        @(negedge clk);
        check_ifid("wrap_top", 32'hFFFF_FFFC);
        check("wrap_addr0", imem_addr, 32'd0);
        @(negedge clk);
        check_ifid("wrap_zero", 32'd0);
        imem_ack = 1'b0;
        @(negedge clk);
        check("wait_req", imem_req, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        check("async_addr", imem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        check("restart_addr", imem_addr, 0);
        @(negedge clk);
        check_ifid("restart", 32'd0);
        exp_pc = 32'd0;
        exp_flush = 1'b0;
        idle = 0;
        for (int i = 0; i < 4000; i++) begin
            if (exp_flush) check("rnd_flush", ifid_valid, 0);
            if (imem_req) check("rnd_align", imem_addr & 32'd3, 0);
            exp_flush = 1'b0;
            stall_id = ($urandom % 4) == 0;
            imem_ack = ($urandom % 3) != 0;
            redirect = !redirect && ($urandom % 20) == 0;
            redirect_pc = $urandom;
            if (redirect) begin
                exp_pc = redirect_pc & ~32'd3;
                exp_flush = 1'b1;
                idle = 0;
            end else if (ifid_valid && !stall_id) begin
                check_ifid("rnd", exp_pc);
                exp_pc = exp_pc + 32'd4;
                idle = 0;
            end else if (++idle > 64) begin
                check("rnd_progress", idle, 0);
                idle = 0;
            end
            @(negedge clk);
        end
        redirect = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the pipelined phase of the processor. It sits directly upstream of the decode/register-bank logic and owns the PC register, the PC+4 incrementer and the IF/ID pipeline register.
- It fetches from instruction memory through a req/ack handshake that tolerates wait states.
- It absorbs decode stalls through a one-entry hold buffer.
- It applies branch/jump redirects, flushing wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_WORD, 32'h0000_0000, instruction value placed in ifid_instr when the register is empty or flushed.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  memory returns imem_rdata this cycle (sampled only while imem_req=1)
- imem_rdata  in  32  fetched instruction word
- stall_id  in  1  decode cannot accept; IF/ID must hold
- redirect  in  1  branch/jump taken; single-cycle pulse
- redirect_pc  in  32  target PC; bits [1:0] ignored, forced to 0
- ifid_valid  out  1  IF/ID holds a valid instruction
- ifid_instr  out  32  registered instruction
- ifid_pc  out  32  PC of ifid_instr
- ifid_pc4  out  32  ifid_pc + 4, modulo 2^32

Behaviour:
- Reset is asynchronous, assert any time:
  - pc=RESET_PC, state=REQ, imem_req=0, ifid_valid=0, ifid_instr=NOP_WORD, ifid_pc=0, ifid_pc4=0.
  - Hold buffer is empty; redirect-pending flag and pending target are cleared.
- First edge after rst_n rises: imem_req=1, imem_addr=RESET_PC.
- State machine has two states, REQ and HOLD.
- REQ:
  - imem_req=1; imem_addr=pc, stable until the ack.
  - On imem_ack with no redirect this cycle and no pending redirect:
    - If (!ifid_valid || !stall_id): load IF/ID (instr=imem_rdata, pc=pc, pc4=pc+4, valid=1); pc<=pc+4; stay in REQ.
    - Else: store {imem_rdata, pc} in the hold buffer; pc<=pc+4; go to HOLD.
  - On imem_ack with a redirect this cycle or a pending redirect: discard imem_rdata; pc<=target; clear pending; stay in REQ.
  - Redirect with no ack: set pending, record target (a later redirect overwrites it); imem_addr unchanged until the ack.
- HOLD:
  - imem_req=0.
  - When !stall_id: move buffer into IF/ID (valid=1); go to REQ.
  - On redirect: drop buffer; pc<=redirect_pc; go to REQ.
- IF/ID consumption: an entry is consumed when ifid_valid && !stall_id. If it is consumed and no new word arrives, ifid_valid<=0 and ifid_instr<=NOP_WORD.
- Flush: redirect clears ifid_valid (instr=NOP_WORD) on the same edge, regardless of stall_id. Redirect has priority over every load path.
- Latency and throughput:
  - Zero-wait memory (ack same cycle as req): req at cycle N, ifid_valid at N+1, sustained one instruction per cycle.
  - Each memory wait state adds one bubble.
- PC wrap: 32'hFFFF_FFFC+4 = 0; ifid_pc4 wraps identically.
- A redirect coincident with the rst_n rising edge is ignored.

Test Plan:
- Reset then zero-wait memory, imem_rdata=addr^32'hA5A5_0000: ifid_pc sequence 0,4,8,12 on consecutive cycles; ifid_valid=1 from cycle 2 after reset release; ifid_pc4=ifid_pc+4.
- Stall: stall_id=1 for 3 cycles while ifid_pc=8:
  - ifid holds PC 8; one further word (PC 12) goes to HOLD; imem_req=0 while in HOLD.
  - After stall_id drops: PC 12 then 16, with no instruction lost or duplicated.
- Redirect with redirect_pc=32'h0000_0103 while ack is delayed 2 cycles:
  - Returned word is discarded; next imem_addr=32'h100.
  - ifid_valid=0 on the cycle after the redirect; first valid ifid_pc=0x100.
- Redirect during HOLD with stall_id=1: buffered word dropped; ifid_valid=0; next fetch at the target; no stale instruction reaches IF/ID.
- Wrap: redirect_pc=32'hFFFF_FFFC: fetches FFFF_FFFC then 0000_0000; ifid_pc4 of the first instruction = 0.
- Async reset asserted mid-wait (imem_req=1, no ack): outputs take their reset values immediately, without waiting for a clock edge; fetch restarts at RESET_PC.
